// File: rtl/regfile_hilo_if.sv
// Write-back, read-port and HI/LO signal bundle for the register file.
interface regfile_hilo_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              hilo_we;
  logic [WIDTH-1:0]  hi_in;
  logic [WIDTH-1:0]  lo_in;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [WIDTH-1:0]  rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [WIDTH-1:0]  rdata2;
  logic [WIDTH-1:0]  hi_out;
  logic [WIDTH-1:0]  lo_out;

  modport master (
    output we, waddr, wdata, hilo_we, hi_in, lo_in,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_out, lo_out
  );

  modport slave (
    input  we, waddr, wdata, hilo_we, hi_in, lo_in,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_out, lo_out
  );
endinterface

// File: rtl/regfile_hilo.sv
// Two-read/one-write register file with HI/LO pair; combinational reads with
// same-cycle write-through bypass, register 0 hard-wired to zero.
module regfile_hilo #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  regfile_hilo_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_wr_valid;
  assign w_wr_valid = bus.we && (bus.waddr != '0);

  // One write-decoded register per address; slot 0 never matches w_wr_valid.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          r_regs[gi] <= '0;
        end else if (w_wr_valid && (bus.waddr == ADDR_W'(gi))) begin
          r_regs[gi] <= bus.wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (bus.hilo_we) begin
      r_hi <= bus.hi_in;
      r_lo <= bus.lo_in;
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end else begin
        bus.rdata1 = r_regs[bus.raddr1];
      end
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end else begin
        bus.rdata2 = r_regs[bus.raddr2];
      end
    end
  end

  always_comb begin
    bus.hi_out = '0;
    bus.lo_out = '0;
    if (!rst) begin
      if (bus.hilo_we) begin
        bus.hi_out = bus.hi_in;
        bus.lo_out = bus.lo_in;
      end else begin
        bus.hi_out = r_hi;
        bus.lo_out = r_lo;
      end
    end
  end
endmodule

// File: tb/tb_regfile_hilo.sv
// Directed self-checking bench for regfile_hilo.
module tb_regfile_hilo;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_hilo_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  regfile_hilo #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.hilo_we = 0; bus.hi_in = 0; bus.lo_in = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    bus.we = 1; bus.waddr = 4; bus.wdata = 32'h1111_2222;
    bus.hilo_we = 1; bus.hi_in = 32'h5; bus.lo_in = 32'h6;
    bus.re1 = 1; bus.raddr1 = 4; bus.re2 = 1; bus.raddr2 = 4;
    tick(); tick();
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=%h", bus.rdata1, 32'h0); end
    total++; if (bus.hi_out !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus.hi_out, 32'h0); end
    rst = 0; idle();
    bus.re1 = 1; bus.raddr1 = 4;
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL reset_r4_cleared got=%h exp=%h", bus.rdata1, 32'h0); end
    total++; if (bus.lo_out !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus.lo_out, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_write_readback();
    idle();
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.re1 = 1; bus.raddr1 = 5; bus.re2 = 1; bus.raddr2 = 5;
    #1;
    total++; if (bus.rdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd_port1 got=%h exp=%h", bus.rdata1, 32'hDEAD_BEEF); end
    total++; if (bus.rdata2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd_port2 got=%h exp=%h", bus.rdata2, 32'hDEAD_BEEF); end
    $display("test_write_readback done");
  endtask

  task automatic test_bypass();
    idle();
    bus.we = 1; bus.waddr = 7; bus.wdata = 32'h1234_5678;
    bus.re1 = 1; bus.raddr1 = 7; bus.re2 = 1; bus.raddr2 = 7;
    #1;
    total++; if (bus.rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_port1 got=%h exp=%h", bus.rdata1, 32'h1234_5678); end
    total++; if (bus.rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_port2 got=%h exp=%h", bus.rdata2, 32'h1234_5678); end
    tick();
    bus.we = 0;
    #1;
    total++; if (bus.rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_stored got=%h exp=%h", bus.rdata1, 32'h1234_5678); end
    // Bypass must override a stale stored value.
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'hCAFE_0001; bus.raddr2 = 5;
    #1;
    total++; if (bus.rdata2 !== 32'hCAFE_0001) begin bad++; $display("FAIL bypass_over_old got=%h exp=%h", bus.rdata2, 32'hCAFE_0001); end
    total++; if (bus.rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_other_port got=%h exp=%h", bus.rdata1, 32'h1234_5678); end
    tick();
    idle();
    $display("test_bypass done");
  endtask

  task automatic test_zero_reg();
    idle();
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFF_FFFF;
    bus.re1 = 1; bus.raddr1 = 0; bus.re2 = 1; bus.raddr2 = 0;
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL zero_same_cycle got=%h exp=%h", bus.rdata1, 32'h0); end
    tick();
    bus.we = 0;
    #1;
    total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL zero_next_cycle got=%h exp=%h", bus.rdata2, 32'h0); end
    $display("test_zero_reg done");
  endtask

  task automatic test_hilo();
    idle();
    bus.hilo_we = 1; bus.hi_in = 32'hAAAA_0000; bus.lo_in = 32'h0000_BBBB;
    #1;
    total++; if (bus.hi_out !== 32'hAAAA_0000) begin bad++; $display("FAIL hilo_bypass_hi got=%h exp=%h", bus.hi_out, 32'hAAAA_0000); end
    total++; if (bus.lo_out !== 32'h0000_BBBB) begin bad++; $display("FAIL hilo_bypass_lo got=%h exp=%h", bus.lo_out, 32'h0000_BBBB); end
    tick();
    bus.hilo_we = 0; bus.hi_in = 32'h1357_9BDF; bus.lo_in = 32'h2468_ACE0;
    #1;
    total++; if (bus.hi_out !== 32'hAAAA_0000) begin bad++; $display("FAIL hilo_stored_hi got=%h exp=%h", bus.hi_out, 32'hAAAA_0000); end
    total++; if (bus.lo_out !== 32'h0000_BBBB) begin bad++; $display("FAIL hilo_stored_lo got=%h exp=%h", bus.lo_out, 32'h0000_BBBB); end
    // Register write and HILO write in the same edge.
    bus.we = 1; bus.waddr = 20; bus.wdata = 32'h0BAD_F00D;
    bus.hilo_we = 1; bus.hi_in = 32'h0000_0011; bus.lo_in = 32'h0000_0022;
    tick();
    idle();
    bus.re1 = 1; bus.raddr1 = 20;
    #1;
    total++; if (bus.rdata1 !== 32'h0BAD_F00D) begin bad++; $display("FAIL dual_write_reg got=%h exp=%h", bus.rdata1, 32'h0BAD_F00D); end
    total++; if (bus.hi_out !== 32'h0000_0011) begin bad++; $display("FAIL dual_write_hi got=%h exp=%h", bus.hi_out, 32'h0000_0011); end
    total++; if (bus.lo_out !== 32'h0000_0022) begin bad++; $display("FAIL dual_write_lo got=%h exp=%h", bus.lo_out, 32'h0000_0022); end
    $display("test_hilo done");
  endtask

  task automatic test_reset_mid();
    idle();
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h55;
    bus.hilo_we = 1; bus.hi_in = 32'h1; bus.lo_in = 32'h2;
    tick();
    idle();
    rst = 1;
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h99;
    bus.hilo_we = 1; bus.hi_in = 32'h7; bus.lo_in = 32'h8;
    bus.re1 = 1; bus.raddr1 = 3; bus.re2 = 1; bus.raddr2 = 3;
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL rstmid_rdata1 got=%h exp=%h", bus.rdata1, 32'h0); end
    total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL rstmid_rdata2 got=%h exp=%h", bus.rdata2, 32'h0); end
    total++; if (bus.hi_out !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h exp=%h", bus.hi_out, 32'h0); end
    total++; if (bus.lo_out !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h exp=%h", bus.lo_out, 32'h0); end
    tick();
    rst = 0;
    bus.we = 0; bus.hilo_we = 0;
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL rstmid_r3_after got=%h exp=%h", bus.rdata1, 32'h0); end
    total++; if (bus.hi_out !== 32'h0) begin bad++; $display("FAIL rstmid_hi_after got=%h exp=%h", bus.hi_out, 32'h0); end
    total++; if (bus.lo_out !== 32'h0) begin bad++; $display("FAIL rstmid_lo_after got=%h exp=%h", bus.lo_out, 32'h0); end
    // First edge after deassert must accept a write.
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'h77;
    tick();
    bus.we = 0;
    #1;
    total++; if (bus.rdata1 !== 32'h77) begin bad++; $display("FAIL rstmid_first_write got=%h exp=%h", bus.rdata1, 32'h77); end
    $display("test_reset_mid done");
  endtask

  task automatic test_re_gating();
    idle();
    bus.we = 1; bus.waddr = 9; bus.wdata = 32'h42;
    tick();
    idle();
    bus.re2 = 0; bus.raddr2 = 9;
    #1;
    total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL re_gated got=%h exp=%h", bus.rdata2, 32'h0); end
    bus.re2 = 1;
    #1;
    total++; if (bus.rdata2 !== 32'h42) begin bad++; $display("FAIL re_enabled got=%h exp=%h", bus.rdata2, 32'h42); end
    // Disabled port ignores the bypass too.
    bus.re1 = 0; bus.raddr1 = 9; bus.we = 1; bus.waddr = 9; bus.wdata = 32'h43;
    #1;
    total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL re_gated_bypass got=%h exp=%h", bus.rdata1, 32'h0); end
    tick();
    idle();
    $display("test_re_gating done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h0000_A001; vals[1] = 32'h0000_B002;
    vals[2] = 32'h0000_C003; vals[3] = 32'h8000_D004;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.we = 1; bus.waddr = 5'(28 + i); bus.wdata = vals[i];
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.re1 = 1; bus.raddr1 = 5'(28 + i);
      bus.re2 = 1; bus.raddr2 = 5'(31 - i);
      #1;
      total++; if (bus.rdata1 !== vals[i]) begin bad++; $display("FAIL b2b_port1 r%0d got=%h exp=%h", 28 + i, bus.rdata1, vals[i]); end
      total++; if (bus.rdata2 !== vals[3 - i]) begin bad++; $display("FAIL b2b_port2 r%0d got=%h exp=%h", 31 - i, bus.rdata2, vals[3 - i]); end
      tick();
    end
    idle();
    $display("test_back_to_back done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    idle();
    test_reset();
    test_write_readback();
    test_bypass();
    test_zero_reg();
    test_hilo();
    test_reset_mid();
    test_re_gating();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of every register, HI and LO.
REQ-002 Parameter ADDR_W, default 5, sets the register address width; 2**ADDR_W registers.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  writeback register-write enable from the MEM/WB register.
REQ-006 waddr  input  ADDR_W  writeback destination register address.
REQ-007 wdata  input  WIDTH  writeback data.
REQ-008 hilo_we  input  1  HILO write enable from the MEM/WB register.
REQ-009 hi_in  input  WIDTH  value for HI.
REQ-010 lo_in  input  WIDTH  value for LO.
REQ-011 re1  input  1  read enable, port 1.
REQ-012 raddr1  input  ADDR_W  read address, port 1.
REQ-013 rdata1  output  WIDTH  read data, port 1, combinational.
REQ-014 re2  input  1  read enable, port 2.
REQ-015 raddr2  input  ADDR_W  read address, port 2.
REQ-016 rdata2  output  WIDTH  read data, port 2, combinational.
REQ-017 hi_out  output  WIDTH  current HI value, combinational.
REQ-018 lo_out  output  WIDTH  current LO value, combinational.

Function
REQ-019 Storage SHALL be 2**ADDR_W registers of WIDTH bits plus HI and LO registers.
REQ-020 On a rising edge with rst=0, we=1 and waddr!=0, the register at waddr SHALL take wdata.
REQ-021 A write to address 0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-022 On a rising edge with rst=0 and hilo_we=1, HI SHALL take hi_in and LO SHALL take lo_in in the same cycle.
REQ-023 If hilo_we=0, HI and LO SHALL hold their values.
REQ-024 Each read port SHALL drive its output with the following priority, highest first:
  (a) rst=1 gives 0.
  (b) reN=0 gives 0.
  (c) raddrN=0 gives 0.
  (d) we=1 and waddr==raddrN gives wdata (same-cycle write-through bypass).
  (e) Otherwise the stored register value.
REQ-025 The read ports SHALL be independent; both ports SHALL be able to read the same address, and both SHALL be able to bypass in the same cycle.
REQ-026 hi_out and lo_out SHALL use the following priority: rst=1 gives 0; hilo_we=1 gives hi_in/lo_in (bypass); otherwise the stored HI/LO.
REQ-027 Read latency SHALL be 0 cycles; write latency SHALL be 1 edge to storage and 0 cycles through the bypass.
REQ-028 A register write and a HILO write in the same cycle SHALL both take effect.
REQ-029 When we=1 and waddr=0, the bypass SHALL NOT apply; a read of address 0 SHALL return 0.

Reset
REQ-030 On a rising edge with rst=1, all registers, HI and LO SHALL clear to 0.
REQ-031 While rst=1, write enables SHALL be ignored, and rdata1, rdata2, hi_out and lo_out SHALL be 0.
REQ-032 If rst is asserted while a write is presented in the same cycle, the reset SHALL win and no write SHALL occur.
REQ-033 The first edge after rst deasserts SHALL accept writes normally.

Verification
REQ-034 Write/readback: reset, then write 0xDEADBEEF to r5; the next cycle, re1=1 and raddr1=5 -> rdata1=0xDEADBEEF.
REQ-035 Bypass: in one cycle we=1, waddr=7, wdata=0x12345678, re1=1, raddr1=7, re2=1, raddr2=7 -> rdata1=rdata2=0x12345678 in that same cycle.
REQ-036 Zero register: write 0xFFFFFFFF to r0, reading r0 in the same cycle and the next -> rdata=0 both cycles.
REQ-037 HILO: hilo_we=1, hi_in=0xAAAA0000, lo_in=0x0000BBBB -> hi_out/lo_out show those values the same cycle (bypass) and after the edge with hilo_we=0 (stored).
REQ-038 Reset mid-operation: after r3=0x55 and HI=0x1, assert rst with we=1, waddr=3, wdata=0x99 -> all outputs read 0 during reset; after deassert, r3, HI and LO read 0.
REQ-039 Read enable gating: r9=0x42 with re2=0 and raddr2=9 -> rdata2=0; then re2=1 -> rdata2=0x42.
